mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

Bus-cycle sequencer between the Processor's memory port and the MemoryInterface. It accepts one word-addressed read or write request at a time and drives MEM_Address, MEM_Data_In and MEM_r_w_z_z. It then waits for MEM_MFC or MEM_ERROR, with a timeout, and returns a one-cycle response carrying the read data and an error code. Between accesses it returns the bus to high impedance and keeps a saturating error count for the hex display.

## Interface
- TIMEOUT_CYCLES, 15: maximum ACCESS cycles without MFC/ERROR before a timeout is declared; legal range 1..255.
- WIDTH, 32: address and data width.

- Clock  in  1  single clock; MemoryInterface runs on the same clock.
- Reset  in  1  asynchronous, active-high.
- REQ_Valid  in  1  request present.
- REQ_Write  in  1  1 = write, 0 = read.
- REQ_Address  in  WIDTH  word address.
- REQ_Data  in  WIDTH  write data.
- REQ_Ready  out  1  high only in IDLE.
- RSP_Valid  out  1  one-cycle completion pulse.
- RSP_Data  out  WIDTH  last successfully read word; held between reads.
- RSP_ErrCode  out  2  valid with RSP_Valid: 00 ok, 01 MEM_ERROR, 10 timeout.
- ERR_Count  out  8  saturating count of errored/timed-out accesses and release timeouts.
- MEM_Address  out  WIDTH  to MemoryInterface.
- MEM_Data_In  out  WIDTH  to MemoryInterface.
- MEM_r_w_z_z  out  2  00 read, 01 write, 10 high impedance.
- MEM_Data_Out  in  WIDTH  from MemoryInterface.
- MEM_MFC  in  1  memory function complete.
- MEM_ERROR  in  1  address not assigned.

## Operation
- States: IDLE, ACCESS, RESPOND, RELEASE.
- IDLE
  - REQ_Ready=1; MEM_r_w_z_z=10.
  - On REQ_Valid=1: latch write/address/data, clear timer, go to ACCESS.
- ACCESS
  - MEM_r_w_z_z={0,write_latched}; MEM_Address and MEM_Data_In are driven from the latches and stay stable for the whole state.
  - Each cycle, in priority order:
    - MEM_ERROR=1: code 01 -> RESPOND.
    - MEM_MFC=1: code 00; on a read, capture MEM_Data_Out into RSP_Data -> RESPOND.
    - timer==TIMEOUT_CYCLES-1: code 10 -> RESPOND.
    - otherwise: timer+1.
- RESPOND
  - RSP_Valid=1 for exactly this cycle with RSP_ErrCode.
  - MEM_r_w_z_z=10.
  - If the code is non-zero, ERR_Count+1 (saturating at 255).
  - Next state is RELEASE.
- RELEASE
  - MEM_r_w_z_z=10.
  - Wait for MEM_MFC=0, then go to IDLE.
  - If MFC stays high for TIMEOUT_CYCLES cycles, go to IDLE anyway and increment ERR_Count (saturating).
- Requests are ignored outside IDLE; the requester must hold REQ_Valid until it sees REQ_Ready=1.
- RSP_Data is unchanged on writes, errors and timeouts.
- RSP_ErrCode holds its last value while RSP_Valid=0.

## Timing
- Reset values:
  - state IDLE, REQ_Ready=1, RSP_Valid=0.
  - RSP_Data=0, RSP_ErrCode=00, ERR_Count=0.
  - MEM_r_w_z_z=10, MEM_Address=0, MEM_Data_In=0, timer=0.
- Reset mid-access aborts immediately (asynchronous): the bus goes to high impedance and no RSP_Valid is issued.
- Acceptance at clock edge N; ACCESS drives the bus from cycle N+1.
- If MFC is sampled high at the end of ACCESS cycle k, RSP_Valid is high during cycle k+1.
  - Minimum request-to-response latency is 2 cycles (MFC in the first ACCESS cycle).
  - Timeout response arrives in cycle N+1+TIMEOUT_CYCLES.
- Back-to-back accesses: IDLE is reached no earlier than 2 cycles after RSP_Valid (RELEASE followed by IDLE), so the minimum issue interval is 4 cycles.
- MFC and ERROR high in the same cycle: ERROR wins.
- MFC and timeout in the same cycle: MFC wins.
- MFC already high on entry to ACCESS is accepted as completion.
- All outputs are registered or decoded from state only; there is no combinational path from REQ_* or MEM_* inputs to any output.

## Test plan
- Read 0x00000004; memory returns 0xDEADBEEF with MFC in the 3rd ACCESS cycle -> RSP_Valid exactly once, 4 cycles after acceptance, RSP_ErrCode=00, RSP_Data=0xDEADBEEF, MEM_r_w_z_z=00 in ACCESS and 10 afterwards.
- Write 0x12345678 to address 0x10; MFC in the 1st ACCESS cycle -> MEM_r_w_z_z=01 and MEM_Data_In=0x12345678 held until MFC; RSP_Valid at acceptance+2; RSP_Data unchanged.
- Read with MEM_ERROR and MFC both high in the 2nd ACCESS cycle -> RSP_ErrCode=01, RSP_Data unchanged, ERR_Count 0->1.
- TIMEOUT_CYCLES=15, memory never responds -> RSP_ErrCode=10 at acceptance+16, ERR_Count increments; 260 repeated timeouts leave ERR_Count=255.
- MFC stuck high after a completed read -> FSM stays in RELEASE for 15 cycles, then IDLE; ERR_Count+1; REQ_Ready=1.
- Reset pulse in the 2nd ACCESS cycle -> MEM_r_w_z_z=10 and REQ_Ready=1 immediately, no RSP_Valid; a subsequent read completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Bus-cycle sequencer: issues one read/write to the MemoryInterface, waits for MFC/ERROR
// with a timeout, returns a one-cycle response and keeps a saturating error count.
//
// state     | meaning
// S_IDLE    | bus released, accepting a request
// S_ACCESS  | bus driven from latched request, waiting for MFC/ERROR/timeout
// S_RESPOND | one-cycle response pulse with error code
// S_RELEASE | bus released, waiting for MFC to drop (bounded)
module mem_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int WIDTH          = 32
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_REQ_Valid,
    input  logic             i_REQ_Write,
    input  logic [WIDTH-1:0] i_REQ_Address,
    input  logic [WIDTH-1:0] i_REQ_Data,
    output logic             o_REQ_Ready,
    output logic             o_RSP_Valid,
    output logic [WIDTH-1:0] o_RSP_Data,
    output logic [1:0]       o_RSP_ErrCode,
    output logic [7:0]       o_ERR_Count,
    output logic [WIDTH-1:0] o_MEM_Address,
    output logic [WIDTH-1:0] o_MEM_Data_In,
    output logic [1:0]       o_MEM_r_w_z_z,
    input  logic [WIDTH-1:0] i_MEM_Data_Out,
    input  logic             i_MEM_MFC,
    input  logic             i_MEM_ERROR
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_ERROR   = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;
    localparam logic [1:0] BUS_HIGHZ    = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_timer;
    logic [7:0]         w_timer_next;
    logic               r_write;
    logic [WIDTH-1:0]   r_address;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [1:0]         r_err_code;
    logic [7:0]         r_err_count;

    logic               w_latch_req;
    logic               w_capture_data;
    logic               w_code_load;
    logic [1:0]         w_code_next;
    logic               w_err_inc;

    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_latch_req    = 1'b0;
        w_capture_data = 1'b0;
        w_code_load    = 1'b0;
        w_code_next    = r_err_code;
        w_err_inc      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_REQ_Valid) begin
                    w_latch_req  = 1'b1;
                    w_timer_next = 8'd0;
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // ERROR beats MFC, and MFC beats a timeout landing in the same cycle
                if (i_MEM_ERROR) begin
                    w_code_load  = 1'b1;
                    w_code_next  = CODE_ERROR;
                    w_state_next = S_RESPOND;
                end else if (i_MEM_MFC) begin
                    w_code_load    = 1'b1;
                    w_code_next    = CODE_OK;
                    w_capture_data = ~r_write;
                    w_state_next   = S_RESPOND;
                end else if (r_timer == TIMER_LAST) begin
                    w_code_load  = 1'b1;
                    w_code_next  = CODE_TIMEOUT;
                    w_state_next = S_RESPOND;
                end else begin
                    w_timer_next = r_timer + 8'd1;
                end
            end
            S_RESPOND: begin
                w_timer_next = 8'd0;
                w_err_inc    = (r_err_code != CODE_OK);
                w_state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (!i_MEM_MFC) begin
                    w_state_next = S_IDLE;
                end else if (r_timer == TIMER_LAST) begin
                    w_err_inc    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_next = r_timer + 8'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state     <= S_IDLE;
            r_timer     <= 8'd0;
            r_write     <= 1'b0;
            r_address   <= '0;
            r_data      <= '0;
            r_rsp_data  <= '0;
            r_err_code  <= CODE_OK;
            r_err_count <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            if (w_latch_req) begin
                r_write   <= i_REQ_Write;
                r_address <= i_REQ_Address;
                r_data    <= i_REQ_Data;
            end
            if (w_capture_data) begin
                r_rsp_data <= i_MEM_Data_Out;
            end
            if (w_code_load) begin
                r_err_code <= w_code_next;
            end
            if (w_err_inc && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign o_REQ_Ready   = (r_state == S_IDLE);
    assign o_RSP_Valid   = (r_state == S_RESPOND);
    assign o_RSP_Data    = r_rsp_data;
    assign o_RSP_ErrCode = r_err_code;
    assign o_ERR_Count   = r_err_count;
    assign o_MEM_Address = r_address;
    assign o_MEM_Data_In = r_data;
    assign o_MEM_r_w_z_z = (r_state == S_ACCESS) ? {1'b0, r_write} : BUS_HIGHZ;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed vector table, randomized
// transactions against a transaction-level model, error saturation and mid-access reset.
module tb_mem_access_sequencer;

    localparam int T = 15;

    logic        i_Clock;
    logic        i_Reset;
    logic        i_REQ_Valid;
    logic        i_REQ_Write;
    logic [31:0] i_REQ_Address;
    logic [31:0] i_REQ_Data;
    logic        o_REQ_Ready;
    logic        o_RSP_Valid;
    logic [31:0] o_RSP_Data;
    logic [1:0]  o_RSP_ErrCode;
    logic [7:0]  o_ERR_Count;
    logic [31:0] o_MEM_Address;
    logic [31:0] o_MEM_Data_In;
    logic [1:0]  o_MEM_r_w_z_z;
    logic [31:0] i_MEM_Data_Out;
    logic        i_MEM_MFC;
    logic        i_MEM_ERROR;

    mem_access_sequencer #(.TIMEOUT_CYCLES(T), .WIDTH(32)) dut (
        .i_Clock        (i_Clock),
        .i_Reset        (i_Reset),
        .i_REQ_Valid    (i_REQ_Valid),
        .i_REQ_Write    (i_REQ_Write),
        .i_REQ_Address  (i_REQ_Address),
        .i_REQ_Data     (i_REQ_Data),
        .o_REQ_Ready    (o_REQ_Ready),
        .o_RSP_Valid    (o_RSP_Valid),
        .o_RSP_Data     (o_RSP_Data),
        .o_RSP_ErrCode  (o_RSP_ErrCode),
        .o_ERR_Count    (o_ERR_Count),
        .o_MEM_Address  (o_MEM_Address),
        .o_MEM_Data_In  (o_MEM_Data_In),
        .o_MEM_r_w_z_z  (o_MEM_r_w_z_z),
        .i_MEM_Data_Out (i_MEM_Data_Out),
        .i_MEM_MFC      (i_MEM_MFC),
        .i_MEM_ERROR    (i_MEM_ERROR)
    );

    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    int checks   = 0;
    int failures = 0;

    // transaction-level model state
    logic [31:0] m_data;
    int          m_err;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          kind;    // bit0: MFC from cycle ev on, bit1: ERROR in cycle ev
        int          ev;
        int          hold;    // MFC high in RESPOND and the first 'hold' RELEASE cycles
        int          code;
        int          rsp;     // ACCESS cycles before RESPOND
        int          rel;     // RELEASE cycles
        logic [31:0] data;
        int          err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit w, input logic [31:0] rd, input int kind, input int ev,
                              input int hold, output int code, output int rsp, output int rel);
        if (kind != 0 && ev <= T) begin
            rsp  = ev;
            code = (kind >= 2) ? 1 : 0;
        end else begin
            rsp  = T;
            code = 2;
        end
        if (!w && code == 0) m_data = rd;
        if (code != 0 && m_err < 255) m_err++;
        rel = (hold >= T) ? T : hold + 1;
        if (hold >= T && m_err < 255) m_err++;
    endtask

    task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int kind, input int ev, input int hold,
                           input int code, input int rsp, input int rel,
                           input logic [31:0] data, input int err);
        @(negedge i_Clock);
        chk("ready_before", 32'(o_REQ_Ready), 32'd1);
        i_REQ_Valid   = 1'b1;
        i_REQ_Write   = w;
        i_REQ_Address = a;
        i_REQ_Data    = wd;
        @(posedge i_Clock); #1;
        // requests outside IDLE must be ignored and must not disturb the bus
        i_REQ_Write   = ~w;
        i_REQ_Address = ~a;
        i_REQ_Data    = ~wd;
        for (int c = 1; c <= rsp; c++) begin
            i_MEM_MFC      = ((kind & 1) != 0) && (c >= ev);
            i_MEM_ERROR    = ((kind & 2) != 0) && (c == ev);
            i_MEM_Data_Out = i_MEM_MFC ? rd : $urandom;
            @(negedge i_Clock);
            chk("access_rwzz", 32'(o_MEM_r_w_z_z), {30'd0, 1'b0, w});
            chk("access_addr", o_MEM_Address, a);
            chk("access_wdata", o_MEM_Data_In, wd);
            chk("access_rsp_valid", 32'(o_RSP_Valid), 32'd0);
            chk("access_ready", 32'(o_REQ_Ready), 32'd0);
            @(posedge i_Clock); #1;
        end
        i_REQ_Valid    = 1'b0;
        i_MEM_ERROR    = 1'b0;
        i_MEM_MFC      = (hold > 0);
        i_MEM_Data_Out = $urandom;
        @(negedge i_Clock);
        chk("respond_valid", 32'(o_RSP_Valid), 32'd1);
        chk("respond_code", 32'(o_RSP_ErrCode), code);
        chk("respond_data", o_RSP_Data, data);
        chk("respond_rwzz", 32'(o_MEM_r_w_z_z), 32'd2);
        chk("respond_ready", 32'(o_REQ_Ready), 32'd0);
        @(posedge i_Clock); #1;
        for (int j = 1; j <= rel; j++) begin
            i_MEM_MFC      = (j <= hold);
            i_MEM_Data_Out = $urandom;
            @(negedge i_Clock);
            chk("release_rwzz", 32'(o_MEM_r_w_z_z), 32'd2);
            chk("release_rsp_valid", 32'(o_RSP_Valid), 32'd0);
            chk("release_ready", 32'(o_REQ_Ready), 32'd0);
            @(posedge i_Clock); #1;
        end
        i_MEM_MFC = 1'b0;
        @(negedge i_Clock);
        chk("idle_ready", 32'(o_REQ_Ready), 32'd1);
        chk("idle_rwzz", 32'(o_MEM_r_w_z_z), 32'd2);
        chk("idle_rsp_valid", 32'(o_RSP_Valid), 32'd0);
        chk("idle_err_count", 32'(o_ERR_Count), err);
        chk("idle_rsp_data", o_RSP_Data, data);
        chk("idle_code_hold", 32'(o_RSP_ErrCode), code);
    endtask

    task automatic run_model(input bit w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int kind, input int ev, input int hold);
        int code, rsp, rel;
        model_step(w, rd, kind, ev, hold, code, rsp, rel);
        run_txn(w, a, wd, rd, kind, ev, hold, code, rsp, rel, m_data, m_err);
    endtask

    initial begin
        //          w     addr          wdata         rdata         kind ev  hold code rsp rel data          err
        vecs[0] = '{1'b0, 32'h00000004, 32'h00000000, 32'hDEADBEEF, 1,   3,  0,   0,   3,  1,  32'hDEADBEEF, 0};
        vecs[1] = '{1'b1, 32'h00000010, 32'h12345678, 32'h55555555, 1,   1,  0,   0,   1,  1,  32'hDEADBEEF, 0};
        vecs[2] = '{1'b0, 32'h00000020, 32'h00000000, 32'hCAFEF00D, 3,   2,  0,   1,   2,  1,  32'hDEADBEEF, 1};
        vecs[3] = '{1'b0, 32'h00000030, 32'h00000000, 32'h11111111, 0,   0,  0,   2,   15, 1,  32'hDEADBEEF, 2};
        vecs[4] = '{1'b0, 32'h00000040, 32'h00000000, 32'h0BADF00D, 1,   1,  20,  0,   1,  15, 32'h0BADF00D, 3};
        vecs[5] = '{1'b1, 32'h00000044, 32'hA5A5A5A5, 32'h00000000, 1,   15, 0,   0,   15, 1,  32'h0BADF00D, 3};
        vecs[6] = '{1'b0, 32'h00000048, 32'h00000000, 32'h77777777, 1,   16, 0,   2,   15, 1,  32'h0BADF00D, 4};
        vecs[7] = '{1'b0, 32'h0000004C, 32'h00000000, 32'h13579BDF, 1,   2,  14,  0,   2,  15, 32'h13579BDF, 4};
        vecs[8] = '{1'b1, 32'h00000050, 32'hFFFFFFFF, 32'h00000000, 2,   1,  0,   1,   1,  1,  32'h13579BDF, 5};
        vecs[9] = '{1'b0, 32'h00000054, 32'h00000000, 32'h2468ACE0, 2,   5,  15,  1,   5,  15, 32'h13579BDF, 7};

        i_Reset        = 1'b1;
        i_REQ_Valid    = 1'b0;
        i_REQ_Write    = 1'b0;
        i_REQ_Address  = '0;
        i_REQ_Data     = '0;
        i_MEM_Data_Out = '0;
        i_MEM_MFC      = 1'b0;
        i_MEM_ERROR    = 1'b0;
        repeat (2) @(posedge i_Clock);
        @(negedge i_Clock);
        chk("reset_ready", 32'(o_REQ_Ready), 32'd1);
        chk("reset_rsp_valid", 32'(o_RSP_Valid), 32'd0);
        chk("reset_rsp_data", o_RSP_Data, 32'd0);
        chk("reset_code", 32'(o_RSP_ErrCode), 32'd0);
        chk("reset_err_count", 32'(o_ERR_Count), 32'd0);
        chk("reset_rwzz", 32'(o_MEM_r_w_z_z), 32'd2);
        chk("reset_addr", o_MEM_Address, 32'd0);
        chk("reset_wdata", o_MEM_Data_In, 32'd0);
        @(posedge i_Clock); #1;
        i_Reset = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].kind, vecs[i].ev,
                    vecs[i].hold, vecs[i].code, vecs[i].rsp, vecs[i].rel, vecs[i].data, vecs[i].err);
        end
        m_data = vecs[9].data;
        m_err  = vecs[9].err;

        for (int n = 0; n < 40; n++) begin
            bit          w;
            int          kind, ev, hold;
            logic [31:0] a, wd, rd;
            w    = 1'($urandom_range(0, 1));
            a    = $urandom;
            wd   = $urandom;
            rd   = $urandom;
            kind = int'($urandom_range(0, 3));
            ev   = int'($urandom_range(1, T + 2));
            hold = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, T + 3));
            run_model(w, a, wd, rd, kind, ev, hold);
        end

        for (int n = 0; n < 260; n++) begin
            run_model(1'b0, 32'h00000100 + n, 32'h0, 32'h0, 0, 0, 0);
        end
        chk("err_saturated", 32'(o_ERR_Count), 32'd255);

        // asynchronous reset in the 2nd ACCESS cycle
        @(negedge i_Clock);
        i_REQ_Valid   = 1'b1;
        i_REQ_Write   = 1'b0;
        i_REQ_Address = 32'h00000060;
        @(posedge i_Clock); #1;
        i_REQ_Valid = 1'b0;
        @(negedge i_Clock);
        chk("pre_reset_rwzz", 32'(o_MEM_r_w_z_z), 32'd0);
        @(posedge i_Clock); #2;
        i_Reset = 1'b1;
        #1;
        chk("async_reset_rwzz", 32'(o_MEM_r_w_z_z), 32'd2);
        chk("async_reset_ready", 32'(o_REQ_Ready), 32'd1);
        chk("async_reset_rsp_valid", 32'(o_RSP_Valid), 32'd0);
        chk("async_reset_err_count", 32'(o_ERR_Count), 32'd0);
        chk("async_reset_addr", o_MEM_Address, 32'd0);
        @(posedge i_Clock); #1;
        i_Reset = 1'b0;
        m_data  = '0;
        m_err   = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_Clock);
            chk("post_reset_no_rsp", 32'(o_RSP_Valid), 32'd0);
        end
        run_model(1'b0, 32'h00000064, 32'h0, 32'h0F0F0F0F, 1, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
